// File: rtl/beep_sched.sv
// Buzzer scheduler: alarm lifecycle FSM (ring/snooze/timeout), hourly chime
// and key click tones, muxed onto the single active-low buzzer pin.
module beep_sched #(
  parameter int SNOOZE_SEC  = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int TIMEOUT_SEC = 60,
  parameter int CHIME_CYC   = 24000000,
  parameter int CHIME_HALF  = 23889,
  parameter int CLICK_CYC   = 1200000,
  parameter int CLICK_HALF  = 31888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] time_num,
  input  logic [15:0] alarm_time,
  input  logic        alarm_en,
  input  logic        chime_en,
  input  logic        key_press,
  input  logic        snooze_req,
  input  logic        stop_req,
  input  logic        melody_beep,
  output logic        melody_en,
  output logic        beep,
  output logic        alarm_active,
  output logic        snooze_active,
  output logic [1:0]  snooze_left
);

  localparam int SEC_MAX = (SNOOZE_SEC > TIMEOUT_SEC) ? SNOOZE_SEC : TIMEOUT_SEC;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int CHC_W   = $clog2(CHIME_CYC + 1);
  localparam int CHP_W   = $clog2(CHIME_HALF + 1);
  localparam int CLC_W   = $clog2(CLICK_CYC + 1);
  localparam int CLP_W   = $clog2(CLICK_HALF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALARM  = 2'd1,
    SNOOZE = 2'd2,
    CHIME  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        time_q;
  logic               valid_q;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [1:0]         snooze_left_q, snooze_left_d;
  logic [CHC_W-1:0]   chime_cnt_q, chime_cnt_d;
  logic [CHP_W-1:0]   chime_ph_q, chime_ph_d;
  logic               chime_tone_q, chime_tone_d;
  logic [CLC_W-1:0]   click_cnt_q, click_cnt_d;
  logic [CLP_W-1:0]   click_ph_q, click_ph_d;
  logic               click_tone_q, click_tone_d;
  logic               beep_q, beep_d;
  logic               melody_en_q, alarm_active_q, snooze_active_q;

  logic [23:0]        alarm_tgt;
  logic               sec_tick, alarm_hit, hour_hit;

  // Event detection; valid_q suppresses events until time_q holds a real sample
  always_comb begin
    alarm_tgt = {alarm_time, 8'h00};
    sec_tick  = valid_q && (time_num != time_q);
    alarm_hit = valid_q && alarm_en && (time_num == alarm_tgt) && (time_q != alarm_tgt);
    hour_hit  = valid_q && chime_en && (time_num[15:0] == 16'h0000) &&
                (time_q[15:0] != 16'h0000);
  end

  // Alarm/chime state machine with second and chime-duration counters
  always_comb begin
    state_d       = state_q;
    sec_cnt_d     = sec_cnt_q;
    snooze_left_d = snooze_left_q;
    chime_cnt_d   = chime_cnt_q;
    case (state_q)
      IDLE: begin
        if (alarm_hit) begin
          state_d   = ALARM;
          sec_cnt_d = '0;
        end else if (hour_hit) begin
          state_d     = CHIME;
          chime_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ALARM: begin
        if (stop_req) begin
          state_d       = IDLE;
          snooze_left_d = 2'(MAX_SNOOZE);
        end else if (snooze_req && (snooze_left_q != 2'd0)) begin
          state_d       = SNOOZE;
          snooze_left_d = snooze_left_q - 2'd1;
          sec_cnt_d     = '0;
        end else if (sec_tick) begin
          if (sec_cnt_q == SEC_W'(TIMEOUT_SEC - 1)) begin
            state_d       = IDLE;
            snooze_left_d = 2'(MAX_SNOOZE);
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end else begin
          state_d = ALARM;
        end
      end
      SNOOZE: begin
        if (stop_req) begin
          state_d       = IDLE;
          snooze_left_d = 2'(MAX_SNOOZE);
        end else if (alarm_hit) begin
          state_d       = ALARM;
          snooze_left_d = 2'(MAX_SNOOZE);
          sec_cnt_d     = '0;
        end else if (sec_tick) begin
          if (sec_cnt_q == SEC_W'(SNOOZE_SEC - 1)) begin
            state_d   = ALARM;
            sec_cnt_d = '0;
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end else begin
          state_d = SNOOZE;
        end
      end
      CHIME: begin
        if (alarm_hit) begin
          state_d   = ALARM;
          sec_cnt_d = '0;
        end else if (chime_cnt_q == CHC_W'(CHIME_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          chime_cnt_d = chime_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Disarming drops any alarm activity, but a running chime finishes
    if (!alarm_en && (state_d != CHIME)) begin
      state_d       = IDLE;
      snooze_left_d = 2'(MAX_SNOOZE);
    end else begin
      snooze_left_d = snooze_left_d;
    end
  end

  // Chime and click square-tone generators plus the registered beep mux
  always_comb begin
    chime_ph_d   = chime_ph_q;
    chime_tone_d = chime_tone_q;
    click_cnt_d  = click_cnt_q;
    click_ph_d   = click_ph_q;
    click_tone_d = click_tone_q;
    if ((state_d == CHIME) && (state_q != CHIME)) begin
      chime_ph_d   = '0;
      chime_tone_d = 1'b1;
    end else if (state_q == CHIME) begin
      if (chime_ph_q == CHP_W'(CHIME_HALF)) begin
        chime_ph_d   = '0;
        chime_tone_d = ~chime_tone_q;
      end else begin
        chime_ph_d = chime_ph_q + 1'b1;
      end
    end else begin
      chime_ph_d = chime_ph_q;
    end
    // Ringing or chiming takes the pin, so a pending click is dropped, not resumed
    if (((state_d == ALARM) && (state_q != ALARM)) ||
        ((state_d == CHIME) && (state_q != CHIME))) begin
      click_cnt_d = '0;
    end else if (key_press && ((state_q == IDLE) || (state_q == SNOOZE))) begin
      click_cnt_d  = CLC_W'(CLICK_CYC);
      click_ph_d   = '0;
      click_tone_d = 1'b1;
    end else if (click_cnt_q != '0) begin
      click_cnt_d = click_cnt_q - 1'b1;
      if (click_ph_q == CLP_W'(CLICK_HALF)) begin
        click_ph_d   = '0;
        click_tone_d = ~click_tone_q;
      end else begin
        click_ph_d = click_ph_q + 1'b1;
      end
    end else begin
      click_cnt_d = '0;
    end
    case (state_q)
      ALARM:   beep_d = melody_beep;
      CHIME:   beep_d = chime_tone_q;
      default: beep_d = (click_cnt_q != '0) ? click_tone_q : 1'b1;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      time_q          <= 24'h000000;
      valid_q         <= 1'b0;
      sec_cnt_q       <= '0;
      snooze_left_q   <= 2'(MAX_SNOOZE);
      chime_cnt_q     <= '0;
      chime_ph_q      <= '0;
      chime_tone_q    <= 1'b1;
      click_cnt_q     <= '0;
      click_ph_q      <= '0;
      click_tone_q    <= 1'b1;
      beep_q          <= 1'b1;
      melody_en_q     <= 1'b0;
      alarm_active_q  <= 1'b0;
      snooze_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      time_q          <= time_num;
      valid_q         <= 1'b1;
      sec_cnt_q       <= sec_cnt_d;
      snooze_left_q   <= snooze_left_d;
      chime_cnt_q     <= chime_cnt_d;
      chime_ph_q      <= chime_ph_d;
      chime_tone_q    <= chime_tone_d;
      click_cnt_q     <= click_cnt_d;
      click_ph_q      <= click_ph_d;
      click_tone_q    <= click_tone_d;
      beep_q          <= beep_d;
      melody_en_q     <= (state_d == ALARM);
      alarm_active_q  <= (state_d == ALARM);
      snooze_active_q <= (state_d == SNOOZE);
    end
  end

  assign beep          = beep_q;
  assign melody_en     = melody_en_q;
  assign alarm_active  = alarm_active_q;
  assign snooze_active = snooze_active_q;
  assign snooze_left   = snooze_left_q;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched: vector table for trigger/snooze, then
// hand-written sequences for timeout, stop, disarm, chime, click and reset.
module tb_beep_sched;

  logic        clk, rst_n;
  logic [23:0] time_num;
  logic [15:0] alarm_time;
  logic        alarm_en, chime_en, key_press, snooze_req, stop_req, melody_beep;
  logic        melody_en, beep, alarm_active, snooze_active;
  logic [1:0]  snooze_left;

  int checks   = 0;
  int failures = 0;
  int cur_sec  = 0;

  beep_sched #(
    .SNOOZE_SEC(5), .MAX_SNOOZE(3), .TIMEOUT_SEC(60),
    .CHIME_CYC(40), .CHIME_HALF(3), .CLICK_CYC(20), .CLICK_HALF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .time_num(time_num), .alarm_time(alarm_time),
    .alarm_en(alarm_en), .chime_en(chime_en), .key_press(key_press),
    .snooze_req(snooze_req), .stop_req(stop_req), .melody_beep(melody_beep),
    .melody_en(melody_en), .beep(beep), .alarm_active(alarm_active),
    .snooze_active(snooze_active), .snooze_left(snooze_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] t;
    logic key, snz, stp, mel;
    logic e_alarm, e_snz;
    logic [1:0] e_left;
    logic e_beep, e_mel;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [23:0] bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cur_sec++;
    time_num = bcd(cur_sec);
    step();
  endtask

  task automatic set_sec(input int s);
    cur_sec  = s;
    time_num = bcd(s);
    step();
  endtask

  initial begin
    int err;
    vecs[0]  = '{24'h072959, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[1]  = '{24'h072959, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[2]  = '{24'h073000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1};
    vecs[3]  = '{24'h073000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
    vecs[4]  = '{24'h073000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1};
    vecs[5]  = '{24'h073000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
    vecs[6]  = '{24'h073000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
    vecs[7]  = '{24'h073000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{24'h073000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{24'h073001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{24'h073002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{24'h073003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[12] = '{24'h073004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{24'h073005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1};

    rst_n = 1'b0; time_num = 24'h072959; alarm_time = 16'h0730;
    alarm_en = 1'b1; chime_en = 1'b0; key_press = 1'b0;
    snooze_req = 1'b0; stop_req = 1'b0; melody_beep = 1'b0;
    #23;
    chk("rst_beep", beep, 1); chk("rst_mel", melody_en, 0);
    chk("rst_alarm", alarm_active, 0); chk("rst_snooze", snooze_active, 0);
    chk("rst_left", snooze_left, 3);
    @(negedge clk); rst_n = 1'b1;

    // Trigger, ring following melody, ignored key press, first snooze
    for (int i = 0; i < 14; i++) begin
      time_num = vecs[i].t; key_press = vecs[i].key; snooze_req = vecs[i].snz;
      stop_req = vecs[i].stp; melody_beep = vecs[i].mel;
      step();
      chk($sformatf("vec%0d_alarm", i), alarm_active, vecs[i].e_alarm);
      chk($sformatf("vec%0d_snooze", i), snooze_active, vecs[i].e_snz);
      chk($sformatf("vec%0d_left", i), snooze_left, vecs[i].e_left);
      chk($sformatf("vec%0d_beep", i), beep, vecs[i].e_beep);
      chk($sformatf("vec%0d_mel", i), melody_en, vecs[i].e_mel);
    end
    key_press = 1'b0; snooze_req = 1'b0; stop_req = 1'b0;
    cur_sec = 7 * 3600 + 30 * 60 + 5;

    // Use up the remaining two snoozes
    for (int n = 0; n < 2; n++) begin
      snooze_req = 1'b1; step(); snooze_req = 1'b0;
      chk("snz_active", snooze_active, 1);
      chk("snz_left", snooze_left, 2'(1 - n));
      for (int k = 0; k < 4; k++) tick();
      chk("snz_still", snooze_active, 1);
      tick();
      chk("snz_rering", alarm_active, 1);
    end
    snooze_req = 1'b1; step(); snooze_req = 1'b0;
    chk("snz4_alarm", alarm_active, 1); chk("snz4_snooze", snooze_active, 0);
    chk("snz4_left", snooze_left, 0);

    // Auto-timeout after 60 seconds of ringing
    for (int k = 0; k < 59; k++) tick();
    chk("tmo_59", alarm_active, 1);
    tick();
    chk("tmo_60", alarm_active, 0); chk("tmo_left", snooze_left, 3);

    // Stop beats snooze in the same cycle; no re-trigger while held
    set_sec(7 * 3600 + 30 * 60);
    chk("stop_ring", alarm_active, 1);
    for (int k = 0; k < 10; k++) tick();
    stop_req = 1'b1; snooze_req = 1'b1; step(); stop_req = 1'b0; snooze_req = 1'b0;
    chk("stop_alarm", alarm_active, 0); chk("stop_snooze", snooze_active, 0);
    chk("stop_left", snooze_left, 3);
    step(); step(); step();
    chk("stop_hold", alarm_active, 0);
    tick();
    chk("stop_next", alarm_active, 0);

    // Disarm during snooze
    set_sec(7 * 3600 + 30 * 60);
    chk("dis_ring", alarm_active, 1);
    snooze_req = 1'b1; step(); snooze_req = 1'b0;
    chk("dis_snz_left", snooze_left, 2);
    alarm_en = 1'b0; step();
    chk("dis_snooze", snooze_active, 0); chk("dis_alarm", alarm_active, 0);
    chk("dis_left", snooze_left, 3);
    alarm_en = 1'b1; step(); step();
    chk("rearm_hold", alarm_active, 0);

    // Hourly chime: square wave of period 8 for 40 cycles
    chime_en = 1'b1;
    set_sec(7 * 3600 + 59 * 60 + 59);
    tick();
    chk("chime_first", beep, 1);
    err = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (beep !== (((k / 4) % 2) == 0)) err++;
      if (alarm_active !== 1'b0) err++;
    end
    chk("chime_wave", err, 0);
    step();
    chk("chime_end", beep, 1);
    step();
    chk("chime_end2", beep, 1);

    // Alarm at 08:00 wins over the chime
    alarm_time = 16'h0800; step();
    chk("set_no_hit", alarm_active, 0);
    set_sec(7 * 3600 + 59 * 60 + 59);
    tick();
    chk("alarm_over_chime", alarm_active, 1);
    melody_beep = 1'b0; step();
    chk("alarm_over_chime_beep", beep, 0);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    chk("alarm_over_chime_stop", alarm_active, 0);

    // Key click in IDLE: square wave of period 6 for 20 cycles
    chime_en = 1'b0; step();
    key_press = 1'b1; step(); key_press = 1'b0;
    chk("click_first", beep, 1);
    err = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (beep !== (((j / 3) % 2) == 0)) err++;
    end
    chk("click_wave", err, 0);
    step();
    chk("click_end", beep, 1);

    // Asynchronous reset in the middle of a ring
    set_sec(7 * 3600 + 59 * 60 + 59);
    tick();
    melody_beep = 1'b0; step();
    chk("pre_rst_beep", beep, 0); chk("pre_rst_mel", melody_en, 1);
    #3; rst_n = 1'b0; #1;
    chk("arst_beep", beep, 1); chk("arst_mel", melody_en, 0);
    chk("arst_alarm", alarm_active, 0); chk("arst_left", snooze_left, 3);
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    chk("post_rst_alarm", alarm_active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beep_sched.md
Name: beep_sched

Overview:
Buzzer scheduler for the clock design. It owns the single active-low buzzer pin and shares it between three sources:
- Alarm melody: external melody player, gated by melody_en.
- Hourly chime: internal square tone.
- Key click: internal square tone.

It also sequences the alarm lifecycle: trigger, snooze, re-ring, stop and auto-timeout. It sits between the time counter/alarm-setting logic and the buzzer pad.

Parameters:
- SNOOZE_SEC, 300: seconds spent in SNOOZE before re-ringing.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.
- TIMEOUT_SEC, 60: seconds of continuous ringing before auto-stop.
- CHIME_CYC, 24000000: chime duration in clk cycles (1 s at 24 MHz).
- CHIME_HALF, 23889: chime half-period in cycles.
- CLICK_CYC, 1200000: click duration in cycles (50 ms).
- CLICK_HALF, 31888: click half-period in cycles.

Ports:
- clk  in  1  system clock, 24 MHz.
- rst_n  in  1  reset.
- time_num  in  24  current time, BCD hh:mm:ss.
- alarm_time  in  16  alarm setting, BCD hh:mm.
- alarm_en  in  1  alarm armed (level).
- chime_en  in  1  hourly chime enabled (level).
- key_press  in  1  one-cycle pulse, any key.
- snooze_req  in  1  one-cycle pulse.
- stop_req  in  1  one-cycle pulse.
- melody_beep  in  1  melody player output, active-low.
- melody_en  out  1  runs melody player; player restarts on rising edge.
- beep  out  1  buzzer drive, active-low, registered.
- alarm_active  out  1  high in ALARM.
- snooze_active  out  1  high in SNOOZE.
- snooze_left  out  2  remaining snoozes.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. On reset:
  - state=IDLE; beep=1; melody_en=0; alarm_active=0; snooze_active=0.
  - snooze_left=MAX_SNOOZE; all counters 0.
- sec_tick: one-cycle pulse whenever time_num differs from its registered previous value. The first cycle after reset produces no tick.
- alarm_hit: alarm_en && time_num=={alarm_time,8'h00} && previous time_num did not match. The edge detection prevents re-trigger within the same second after a stop.
- hour_hit: chime_en && time_num[15:0]==16'h0000 && previous did not match.
- States: IDLE, ALARM, SNOOZE, CHIME.
- IDLE:
  - alarm_hit -> ALARM; alarm_hit wins over a simultaneous hour_hit.
  - Otherwise hour_hit -> CHIME.
- ALARM:
  - Entry clears sec_cnt and asserts melody_en.
  - stop_req -> IDLE, snooze_left=MAX_SNOOZE.
  - snooze_req with snooze_left>0 -> SNOOZE, snooze_left decremented.
  - snooze_req with snooze_left==0 is ignored.
  - sec_cnt reaching TIMEOUT_SEC -> IDLE, snooze_left reset.
  - If stop_req and snooze_req arrive in the same cycle, stop wins.
  - key_press and hour_hit are ignored.
- SNOOZE:
  - melody_en=0; sec_cnt counts sec_ticks.
  - At SNOOZE_SEC -> ALARM.
  - stop_req -> IDLE, snooze_left reset.
  - alarm_hit -> ALARM, snooze_left reset.
  - hour_hit is ignored.
- CHIME:
  - Lasts CHIME_CYC cycles, then -> IDLE.
  - alarm_hit aborts the chime -> ALARM in the same cycle.
- Any state: alarm_en low -> IDLE within 1 cycle, snooze_left reset. Chime is unaffected by alarm_en.
- Click overlay:
  - key_press in IDLE or SNOOZE loads click_cnt=CLICK_CYC and restarts the click tone.
  - key_press during an active click restarts it.
  - Entering ALARM or CHIME cancels the click.
- Tone generators:
  - Each tone starts high on entry.
  - The phase counter counts 0..HALF; the tone toggles and the counter clears when it equals HALF.
- Beep mux, registered one cycle:
  - ALARM: melody_beep.
  - CHIME: chime tone.
  - Click active: click tone.
  - Otherwise: 1.
- Counter widths: sized by $clog2 of the corresponding parameter.
- Reset asserted mid-operation: all outputs return to their reset values immediately.

Test Plan:
- alarm_time=16'h0730, alarm_en=1, time_num steps to 24'h073000 -> next cycle alarm_active=1 and melody_en=1; beep follows melody_beep one cycle later.
- Ring then snooze_req (SNOOZE_SEC=5 in sim) -> snooze_active=1, beep=1, snooze_left=2; after 5 sec_ticks, alarm_active=1 again.
- Snooze 3 times, then a 4th snooze_req -> stays ALARM; then 60 sec_ticks -> IDLE, snooze_left=3.
- stop_req at 07:30:10 while time_num is held -> IDLE. No re-trigger while 07:30:00 is not re-entered.
- time_num 24'h075959 -> 24'h080000 with chime_en=1 -> chime square on beep, period 2×(CHIME_HALF+1); ends after CHIME_CYC. An alarm set to 08:00 instead yields ALARM, not CHIME.
- key_press in IDLE -> click tone for CLICK_CYC. key_press during ALARM -> no effect. rst_n pulse mid-ring -> beep=1, melody_en=0 asynchronously.
